// File: rtl/adaptiv_array_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adaptiv_array_ctrl
// Purpose  : Tile sequencer for an output-stationary MAC systolic array.
//            Accepts one tile command (K, mode), then runs feed+flush with
//            skewed per-lane operand enables, then drains the stationary
//            results one row per accepted beat under downstream backpressure.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cfg_valid/ready/k/mode    - tile command handshake
//            feed_stall                - operand source not ready
//            row_feed_en, col_feed_en  - per-lane operand pop enables
//            ctl_stat_bit, ctl_op2_select, ctl_out_select - array controls
//            out_valid/ready, out_row  - result row handshake and row index
//            busy, done                - status (done is a one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module adaptiv_array_ctrl #(
    parameter int ROWS      = 64,
    parameter int COLS      = 16,
    parameter int K_WIDTH   = 16,
    parameter int ROW_IDX_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [K_WIDTH-1:0]   cfg_k,
    input  logic                 cfg_mode,
    input  logic                 feed_stall,
    output logic [ROWS-1:0]      row_feed_en,
    output logic [COLS-1:0]      col_feed_en,
    output logic                 ctl_stat_bit,
    output logic                 ctl_op2_select,
    output logic                 ctl_out_select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_IDX_W-1:0] out_row,
    output logic                 busy,
    output logic                 done
);

    // Counter is one bit wider than K so the feed+flush span never wraps;
    // comparisons use one extra bit so lane windows (lane + K) cannot overflow.
    localparam int c_CW = K_WIDTH + 1;
    localparam int c_XW = K_WIDTH + 2;
    localparam logic [c_XW-1:0] c_FLUSH_M1 = c_XW'(ROWS + COLS - 2);
    localparam logic [c_CW-1:0] c_LAST_ROW = c_CW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [K_WIDTH-1:0] r_k;
    logic              r_mode;

    logic [c_XW-1:0]   w_cnt_x;
    logic [c_XW-1:0]   w_k_x;
    logic              w_feeding;
    logic              w_feed_last;
    logic              w_accept;

    assign w_cnt_x     = {1'b0, r_cnt};
    assign w_k_x       = {2'b00, r_k};
    assign w_feeding   = (r_state == S_FEED) && !feed_stall;
    // Last feed/flush step is cnt == K + ROWS + COLS - 2.
    assign w_feed_last = (w_cnt_x == (w_k_x + c_FLUSH_M1));
    assign w_accept    = (r_state == S_IDLE) && cfg_valid;

    // Lane i is active during steps [i, i+K): the skew lines the wavefront
    // up diagonally across the array.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_en
        localparam logic [c_XW-1:0] c_R = c_XW'(r);
        assign row_feed_en[r] = w_feeding && (w_cnt_x >= c_R) && (w_cnt_x < (c_R + w_k_x));
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_en
        localparam logic [c_XW-1:0] c_C = c_XW'(c);
        assign col_feed_en[c] = w_feeding && (w_cnt_x >= c_C) && (w_cnt_x < (c_C + w_k_x));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_k    <= cfg_k;
                r_mode <= cfg_mode;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_cnt_nxt   = '0;
                    // A zero-length tile has nothing to feed or drain.
                    w_state_nxt = (cfg_k != '0) ? S_FEED : S_DONE;
                end
            end
            S_FEED: begin
                if (!feed_stall) begin
                    if (w_feed_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ROW) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cfg_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign out_valid      = (r_state == S_DRAIN);
    // Row index is only meaningful while draining; held at 0 otherwise.
    assign out_row        = out_valid ? r_cnt[ROW_IDX_W-1:0] : '0;
    // Array shifts its stationary results only on an accepted beat.
    assign ctl_stat_bit   = out_valid && out_ready;
    assign ctl_op2_select = busy && r_mode;
    assign ctl_out_select = busy && r_mode;

endmodule
`default_nettype wire
